// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
//   Emulates the ten HD44102-style column controllers of the Model 100 LCD as
//   seen from the CPU strobe bus. Controller commands are decoded into
//   per-chip address/mode state, and data writes are turned into a serialized
//   framebuffer write port so a captured screen can be mirrored or re-driven.
//
//   Optional feature macro: LCD_READBACK_EN (status and data read-back).
//   Without it, data_out/data_oe/fb_re are tied to 0 and fb_rdata is unused.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   data_pin[7:0]     LCD data bus (asynchronous)
//   cs_pin[NCHIPS-1:0] chip selects, active-high, bit i = chip i (async)
//   di_pin            0 = command/status, 1 = data (async)
//   rw_pin            0 = write, 1 = read (async)
//   enable_pin        bus strobe (async)
//   fb_we             framebuffer write strobe, one cycle per chip write
//   fb_chip/page/col  framebuffer address of the write (or read)
//   fb_data           byte to write
//   disp_on           per-chip display-on flags
//   overrun           sticky: a strobe completed while the serializer was busy
//   data_out, data_oe read-back byte and its drive enable (feature only)
//   fb_re, fb_rdata   framebuffer read strobe / data one cycle later (feature only)
//   ser_state         serializer state for observation (0 = IDLE, 1 = WRITE)
//
// Bus protocol: the bus carries no handshake. While the synchronized enable is
// high the whole bus is latched every cycle; the falling edge of the
// synchronized enable marks one transaction using the last latched values.
// A transaction with no chip selected is ignored. The serializer has no
// back-pressure: a transaction arriving while it is busy is dropped and
// flagged on overrun.

module lcd_bus_responder #(
   parameter int NCHIPS      = 10,
   parameter int NCOLS       = 50,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        data_pin,
   input  logic [NCHIPS-1:0] cs_pin,
   input  logic              di_pin,
   input  logic              rw_pin,
   input  logic              enable_pin,
   output logic              fb_we,
   output logic [3:0]        fb_chip,
   output logic [1:0]        fb_page,
   output logic [5:0]        fb_col,
   output logic [7:0]        fb_data,
   output logic [NCHIPS-1:0] disp_on,
   output logic              overrun,
   output logic [7:0]        data_out,
   output logic              data_oe,
   output logic              fb_re,
   input  logic [7:0]        fb_rdata,
   output logic              ser_state
);

   localparam int         BW       = 8 + NCHIPS + 3;
   localparam logic [5:0] COL_LAST = 6'(NCOLS - 1);

   typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

   function automatic logic [3:0] lowest(input logic [NCHIPS-1:0] m);
      logic [3:0] r;
      r = '0;
      for (int i = NCHIPS - 1; i >= 0; i--) begin
         if (m[i]) r = 4'(i);
      end
      return r;
   endfunction

   // Column stepping after an access: wraps inside 0..NCOLS-1 in both directions.
   function automatic logic [5:0] step_col(input logic [5:0] c, input logic u);
      if (u) return (c == COL_LAST) ? 6'd0 : c + 6'd1;
      else   return (c == 6'd0) ? COL_LAST : c - 6'd1;
   endfunction

   // ---------------- input synchronizers ----------------
   logic [BW-1:0]     sync_q [SYNC_STAGES];
   logic [7:0]        data_s;
   logic [NCHIPS-1:0] cs_s;
   logic              di_s, rw_s, enable_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= {data_pin, cs_pin, di_pin, rw_pin, enable_pin};
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign {data_s, cs_s, di_s, rw_s, enable_s} = sync_q[SYNC_STAGES-1];

   // ---------------- bus latch and edge detect ----------------
   logic              enable_d;
   logic [7:0]        lat_data;
   logic [NCHIPS-1:0] lat_cs;
   logic              lat_di, lat_rw;

   always_ff @(posedge clk) begin
      if (reset) begin
         enable_d <= 1'b0;
         lat_data <= '0;
         lat_cs   <= '0;
         lat_di   <= 1'b0;
         lat_rw   <= 1'b0;
      end else begin
         enable_d <= enable_s;
         if (enable_s) begin
            lat_data <= data_s;
            lat_cs   <= cs_s;
            lat_di   <= di_s;
            lat_rw   <= rw_s;
         end
      end
   end

   logic fall, trig_valid, idle, cmd_go, wr_go, rd_step, ovr_hit;
   state_t state, state_next;

`ifdef LCD_READBACK_EN
   localparam logic RD_EN = 1'b1;
`else
   localparam logic RD_EN = 1'b0;
`endif

   assign fall = enable_d & ~enable_s;
   // Reads only count as transactions when read-back exists; otherwise they
   // are invisible (no overrun, no address step).
   assign trig_valid = fall & (|lat_cs) & (~lat_rw | RD_EN);
   assign idle       = (state == S_IDLE);
   assign cmd_go     = trig_valid & idle & ~lat_di & ~lat_rw;
   assign wr_go      = trig_valid & idle &  lat_di & ~lat_rw;
   assign rd_step    = trig_valid & idle &  lat_di &  lat_rw;
   assign ovr_hit    = trig_valid & ~idle;

   // ---------------- serializer FSM ----------------
   logic [NCHIPS-1:0] mask;
   logic [NCHIPS-1:0] mask_rest;
   logic [7:0]        wr_data;
   logic [3:0]        wr_chip;

   assign mask_rest = mask & (mask - NCHIPS'(1));  // drop the lowest set bit
   assign wr_chip   = lowest(mask);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (wr_go) state_next = S_WRITE;
         S_WRITE: if (mask_rest == '0) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask    <= '0;
         wr_data <= '0;
      end else if (wr_go) begin
         mask    <= lat_cs;
         wr_data <= lat_data;
      end else if (state == S_WRITE) begin
         mask    <= mask_rest;
      end
   end

   // ---------------- per-chip controller state ----------------
   logic [NCHIPS-1:0][1:0] page;
   logic [NCHIPS-1:0][5:0] col;
   logic [NCHIPS-1:0][1:0] start_page;
   logic [NCHIPS-1:0]      up;
   logic [3:0]             rd_chip;

   assign rd_chip = lowest(lat_cs);

   always_ff @(posedge clk) begin
      if (reset) begin
         page       <= '0;
         col        <= '0;
         start_page <= '0;
         up         <= '1;
         disp_on    <= '0;
      end else begin
         if (cmd_go) begin
            for (int i = 0; i < NCHIPS; i++) begin
               if (lat_cs[i]) begin
                  case (lat_data)
                     8'h38: disp_on[i] <= 1'b0;
                     8'h39: disp_on[i] <= 1'b1;
                     8'h3A: up[i]      <= 1'b0;
                     8'h3B: up[i]      <= 1'b1;
                     default: begin
                        if (lat_data[5:0] == 6'h3E) begin
                           start_page[i] <= lat_data[7:6];
                        end else if (lat_data[5:0] <= COL_LAST) begin
                           page[i] <= lat_data[7:6];
                           col[i]  <= lat_data[5:0];
                        end
                     end
                  endcase
               end
            end
         end
         // cmd_go/rd_step need IDLE, this needs WRITE: never the same cycle.
         if (state == S_WRITE) col[wr_chip] <= step_col(col[wr_chip], up[wr_chip]);
         if (rd_step)          col[rd_chip] <= step_col(col[rd_chip], up[rd_chip]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)        overrun <= 1'b0;
      else if (ovr_hit) overrun <= 1'b1;
   end

   // Start page only affects display scan, which this block does not model.
   logic unused_start_page;
   assign unused_start_page = ^start_page;

   // ---------------- read-back ----------------
   logic fb_re_c;
   logic [3:0] lc;

`ifdef LCD_READBACK_EN
   logic rise, rd_pend, data_oe_q;
   logic [7:0] data_out_q;

   assign rise    = enable_s & ~enable_d;
   assign lc      = lowest(cs_s);
   assign fb_re_c = rise & rw_s & di_s & (|cs_s) & idle;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend    <= 1'b0;
         data_oe_q  <= 1'b0;
         data_out_q <= '0;
      end else begin
         rd_pend <= fb_re_c;
         if (rise & rw_s & (|cs_s)) begin
            data_oe_q <= 1'b1;
            if (!di_s) data_out_q <= {1'b0, up[lc], disp_on[lc], 1'b0, 4'b0};
         end else if (fall) begin
            data_oe_q <= 1'b0;
         end
         if (rd_pend) data_out_q <= fb_rdata;
      end
   end

   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^fb_rdata;
   assign lc       = '0;
   assign fb_re_c  = 1'b0;
   assign data_out = '0;
   assign data_oe  = 1'b0;
`endif

   // ---------------- outputs ----------------
   always_comb begin
      fb_we   = 1'b0;
      fb_chip = '0;
      fb_page = '0;
      fb_col  = '0;
      fb_data = '0;
      fb_re   = fb_re_c;
      if (state == S_WRITE) begin
         fb_we   = 1'b1;
         fb_chip = wr_chip;
         fb_page = page[wr_chip];
         fb_col  = col[wr_chip];
         fb_data = wr_data;
      end else if (fb_re_c) begin
         fb_chip = lc;
         fb_page = page[lc];
         fb_col  = col[lc];
      end
   end

   assign ser_state = (state == S_WRITE);

endmodule
